// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard event receiver:
//   - scan-code constants for the extended prefix, break prefix and the two
//     keyboard error/overrun codes
//   - frame FSM state encoding
//   - event layout {ext, brk, code[7:0]} as stored in the event FIFO
//   - odd-parity helper
// ---------------------------------------------------------------------------
package ps2_pkg;

  localparam logic [7:0] PS2_EXT  = 8'hE0;  // extended-key prefix
  localparam logic [7:0] PS2_BRK  = 8'hF0;  // key-release prefix
  localparam logic [7:0] PS2_ERR0 = 8'h00;  // keyboard error / overrun
  localparam logic [7:0] PS2_ERR1 = 8'hFF;  // keyboard error / overrun

  // Frame receiver states. IDLE waits for a start bit, DATA shifts 8 bits
  // LSB first, PARITY captures the parity bit, STOP checks the stop bit.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  // One decoded key event as held in the FIFO.
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  localparam int EVENT_W = $bits(ps2_event_t);

  // PS/2 uses odd parity: data bits plus the parity bit hold an odd number
  // of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data,
                                         input logic       par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ---------------------------------------------------------------------------
// ps2_event_fifo
// Synchronous first-word-fall-through FIFO. The head entry is presented on
// rdata whenever the FIFO is non-empty; rdata reads as zero when empty so
// the consumer never sees stale or uninitialised storage.
//
// Ports
//   clk    in   system clock
//   clrn   in   asynchronous active-low reset (empties the FIFO)
//   push   in   write request for wdata
//   wdata  in   WIDTH-bit entry to write
//   pop    in   remove the head entry (ignored when empty)
//   rdata  out  head entry (FWFT), zero when empty
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
//   count  out  occupancy, 0..DEPTH
//   drop   out  1 in a cycle where a push was refused because the FIFO was
//               full and no pop freed a slot
//
// A push into a full FIFO is accepted when a pop happens in the same cycle;
// the freed slot is reused and the occupancy stays at DEPTH.
// ---------------------------------------------------------------------------
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; empty gating on rdata hides its contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_rx.sv
// ---------------------------------------------------------------------------
// ps2_key_event_rx
// PS/2 keyboard receiver. Synchronises the PS/2 clock and data pins, frames
// 11-bit PS/2 words (start, 8 data LSB first, odd parity, stop), folds the
// E0 (extended) and F0 (break) prefixes into a single event per key and
// buffers events in a first-word-fall-through FIFO.
//
// Ports
//   clk        in   system clock
//   clrn       in   asynchronous active-low reset
//   ps2_clk    in   PS/2 clock pin (asynchronous)
//   ps2_data   in   PS/2 data pin (asynchronous)
//   ev_code    out  head event scan code
//   ev_ext     out  head event carried an E0 prefix
//   ev_break   out  head event is a key release (F0 prefix)
//   ev_valid   out  an event is available
//   ev_ready   in   consumer accepts the head event
//   ev_count   out  FIFO occupancy
//   overflow   out  sticky: an event was dropped because the FIFO was full
//   ovf_clr    in   synchronous clear of overflow (a drop in the same cycle
//                   wins)
//   parity_err out  1-cycle pulse: frame discarded for bad parity
//   frame_err  out  1-cycle pulse: frame discarded for bad stop bit/timeout
//
// Event handshake: ev_code/ev_ext/ev_break are meaningful only while
// ev_valid is 1; they stay stable until the cycle in which ev_valid and
// ev_ready are both 1, which removes the head event at that clock edge.
// ev_ready while ev_valid is 0 has no effect.
//
// The frame FSM state is held in the signal "state" (frame_state_t) as the
// observation point for checkers.
//
// Timing: the stop-bit fall is seen in cycle N, byte_done is registered in
// N+1 and the decoder pushes combinationally in N+1, so ev_valid rises in
// N+2.
// ---------------------------------------------------------------------------
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          parity_err,
  output logic                          frame_err
);

  localparam int                TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYC - 1);

  // -------------------------------------------------------------------------
  // Synchronisers and fall detection
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_cur;
  logic                   data_cur;
  logic                   fall;

  assign clk_cur  = clk_sync[SYNC_STAGES-1];
  assign data_cur = data_sync[SYNC_STAGES-1];
  assign fall     = clk_prev && !clk_cur;

  // The chains reset to 1 (idle bus level) so releasing reset with the bus
  // idle never produces a phantom fall.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_cur;
    end
  end

  // -------------------------------------------------------------------------
  // Frame FSM with timeout. Advances only on falls; the timeout counter runs
  // in every non-idle cycle without a fall and restarts on each fall.
  // -------------------------------------------------------------------------
  frame_state_t   state;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           par_bit;
  logic [TW-1:0]  tmo_cnt;
  logic           byte_done;
  logic [7:0]     byte_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tmo_cnt    <= '0;
      byte_done  <= 1'b0;
      byte_q     <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_done  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tmo_cnt <= '0;
        case (state)
          ST_IDLE: begin
            // A high data line on a fall is not a start bit; ignore it.
            if (!data_cur) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end
          ST_DATA: begin
            shreg <= {data_cur, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= ST_PARITY;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
          ST_PARITY: begin
            par_bit <= data_cur;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            // Bad parity takes precedence over a bad stop bit.
            if (!odd_parity_ok(shreg, par_bit)) begin
              parity_err <= 1'b1;
            end else if (!data_cur) begin
              frame_err <= 1'b1;
            end else begin
              byte_done <= 1'b1;
              byte_q    <= shreg;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        if (tmo_cnt == TMO_LAST) begin
          state     <= ST_IDLE;
          frame_err <= 1'b1;
          tmo_cnt   <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scan-code decoder. Prefix bytes only set flags; a key byte pushes one
  // event carrying the accumulated flags and then clears them. Error codes
  // and discarded frames clear the flags so a broken sequence cannot leak
  // its prefixes into the next key.
  // -------------------------------------------------------------------------
  logic        ext_flag;
  logic        brk_flag;
  logic        ev_push;
  ps2_event_t  ev_wdata;
  logic        is_prefix;
  logic        is_errcode;

  assign is_prefix  = (byte_q == PS2_EXT) || (byte_q == PS2_BRK);
  assign is_errcode = (byte_q == PS2_ERR0) || (byte_q == PS2_ERR1);

  always_comb begin
    ev_push       = byte_done && !is_prefix && !is_errcode;
    ev_wdata      = '0;
    ev_wdata.ext  = ext_flag;
    ev_wdata.brk  = brk_flag;
    ev_wdata.code = byte_q;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (byte_done) begin
      if (byte_q == PS2_EXT) begin
        ext_flag <= 1'b1;
      end else if (byte_q == PS2_BRK) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end else if (parity_err || frame_err) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Event FIFO
  // -------------------------------------------------------------------------
  logic [EVENT_W-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_drop;
  ps2_event_t         head;

  ps2_event_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (ev_push),
    .wdata (ev_wdata),
    .pop   (ev_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (ev_count),
    .drop  (fifo_drop)
  );

  assign head     = ps2_event_t'(fifo_rdata);
  assign ev_code  = head.code;
  assign ev_ext   = head.ext;
  assign ev_break = head.brk;
  assign ev_valid = !fifo_empty;

  // Sticky overflow; a drop in the same cycle as ovf_clr keeps it set.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule
